ahb_sram_responder: RTL and testbench

//   AHB-style responder (slave) fronting the single-port frame SRAM of the edge-detection

---
 rtl/ahb_sram_responder.sv | 135 +++++++++++++
 tb/tb_ahb_sram_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_sram_responder: AHB-style responder fronting a single-port frame SRAM  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ahb_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic              hwrite,
  input  logic [31:0]       hwdata,
  output logic              hready,
  output logic [31:0]       hrdata,
  output logic              hresp,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ren,
  output logic              sram_wen,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                hready_q, hready_d;
  logic                hresp_q, hresp_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic [31:0]         hrdata_q, hrdata_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [32:0]         diff;
  logic [31:0]         off;
  logic                legal;

  // Bit 32 of the widened difference is the borrow: set when haddr < BASE_ADDR.
  always_comb begin
    diff  = {1'b0, haddr} - {1'b0, BASE_ADDR};
    off   = diff[31:0];
    legal = !diff[32] && (off[1:0] == 2'b00) && ((off >> (ADDR_W + 2)) == 32'd0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hrdata_d = hrdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (hsel) begin
          if (!legal) begin
            state_d = S_ERR;
          end else begin
            addr_d = off[ADDR_W+1:2];
            if (hwrite) begin
              state_d = S_WR;
              wdata_d = hwdata;
            end else begin
              state_d = S_RD_REQ;
            end
          end
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
        cnt_d   = 3'(RD_LAT - 1);
      end
      S_RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          hrdata_d = sram_rdata;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WR:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered with it.
    hready_d = (state_d == S_IDLE);
    ren_d    = (state_d == S_RD_REQ);
    wen_d    = (state_d == S_WR);
    hresp_d  = (state_d == S_ERR) || (state_q == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      hrdata_q <= 32'd0;
      wdata_q  <= 32'd0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      hrdata_q <= hrdata_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
    end
  end

  assign hready     = hready_q;
  assign hresp      = hresp_q;
  assign hrdata     = hrdata_q;
  assign sram_addr  = addr_q;
  assign sram_ren   = ren_q;
  assign sram_wen   = wen_q;
  assign sram_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ahb_sram_responder: scoreboard bench, three responders at RD_LAT 2/1/7  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ahb_sram_responder;

  localparam int N = 3;

  typedef struct {
    logic [31:0] data;
    logic [31:0] wdata;
    logic [15:0] word;
    int          low;
    logic        err;
    int          ren;
    int          wen;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          hsel = '0;
  logic [N-1:0]          hwrite = '0;
  logic [N-1:0][31:0]    haddr = '0;
  logic [N-1:0][31:0]    hwdata = '0;
  logic [N-1:0]          hready, hresp, sram_ren, sram_wen;
  logic [N-1:0][31:0]    hrdata, sram_wdata, sram_rdata;
  logic [N-1:0][15:0]    sram_addr;

  exp_t        sb [N][$];
  logic [31:0] shadow [N][65536];
  logic [31:0] last_rd [N];
  int          ren_tot [N];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 7);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);

    ahb_sram_responder #(.BASE_ADDR(32'h0), .ADDR_W(16), .RD_LAT(L)) u_dut (
      .clk(clk), .rst(rst), .hsel(hsel[g]), .haddr(haddr[g]), .hwrite(hwrite[g]),
      .hwdata(hwdata[g]), .hready(hready[g]), .hrdata(hrdata[g]), .hresp(hresp[g]),
      .sram_addr(sram_addr[g]), .sram_ren(sram_ren[g]), .sram_wen(sram_wen[g]),
      .sram_wdata(sram_wdata[g]), .sram_rdata(sram_rdata[g])
    );

    // SRAM model: data emerges L edges after the ren cycle, junk otherwise.
    logic [31:0] mem [65536];
    logic [31:0] pd [1:8];
    logic [8:1]  pv = '0;
    initial mem[4] = 32'hA5A5_0004;
    always @(posedge clk) begin
      if (sram_wen[g]) mem[sram_addr[g]] <= sram_wdata[g];
      pv[1] <= sram_ren[g];
      pd[1] <= mem[sram_addr[g]];
      for (int k = 2; k <= 8; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end
    assign sram_rdata[g] = pv[L] ? pd[L] : 32'hBAD0_BAD0;

    int          run = 0, nren = 0, nwen = 0, nboth = 0;
    logic        prev = 1'b1;
    logic [15:0] saddr = '0;
    logic [31:0] swd = '0;
    exp_t        e;
    always @(negedge clk) begin
      if (sram_ren[g]) ren_tot[g] = ren_tot[g] + 1;
      if (mon_en) begin
        if (!hready[g]) begin
          run++;
          if (sram_ren[g]) begin nren++; saddr = sram_addr[g]; end
          if (sram_wen[g]) begin nwen++; saddr = sram_addr[g]; swd = sram_wdata[g]; end
          if (sram_ren[g] && sram_wen[g]) nboth++;
        end else if (!prev) begin
          if (sb[g].size() == 0) begin
            check($sformatf("u%0d_unexpected_done", g), 1, 0);
          end else begin
            e = sb[g].pop_front();
            check($sformatf("u%0d_low_cycles", g), 64'(run), 64'(e.low));
            check($sformatf("u%0d_hresp", g), 64'(hresp[g]), 64'(e.err));
            check($sformatf("u%0d_hrdata", g), 64'(hrdata[g]), 64'(e.data));
            check($sformatf("u%0d_ren_count", g), 64'(nren), 64'(e.ren));
            check($sformatf("u%0d_wen_count", g), 64'(nwen), 64'(e.wen));
            check($sformatf("u%0d_both_strobes", g), 64'(nboth), 64'd0);
            if (e.ren + e.wen > 0) check($sformatf("u%0d_sram_addr", g), 64'(saddr), 64'(e.word));
            if (e.wen > 0) check($sformatf("u%0d_sram_wdata", g), 64'(swd), 64'(e.wdata));
          end
          run = 0; nren = 0; nwen = 0; nboth = 0;
        end
      end
      prev = hready[g];
    end
  end

  task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, input bit abort);
    exp_t e;
    bit   ok;
    int   n;
    n = 0;
    while (hready[i] !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        check("issue_timeout", 0, 1);
        return;
      end
    end
    ok      = (a[1:0] == 2'b00) && (a[31:18] == 14'd0);
    e.word  = a[17:2];
    e.wdata = d;
    e.err   = !ok;
    e.ren   = (ok && !wr) ? 1 : 0;
    e.wen   = (ok && wr) ? 1 : 0;
    e.low   = !ok ? 1 : (wr ? 1 : lat_of(i) + 1);
    if (ok && wr)  shadow[i][a[17:2]] = d;
    if (ok && !wr) last_rd[i] = shadow[i][a[17:2]];
    if (abort) begin
      e.low      = 2;
      last_rd[i] = 32'd0;
    end
    e.data = last_rd[i];
    sb[i].push_back(e);
    hsel[i] = 1'b1; hwrite[i] = wr; haddr[i] = a; hwdata[i] = d;
    @(posedge clk); #1;
    if (!hold) hsel[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (hready[i] !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        check("idle_timeout", 0, 1);
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int c0, r0;
    for (int i = 0; i < N; i++) begin
      shadow[i][4] = 32'hA5A5_0004;
      last_rd[i]   = 32'd0;
      ren_tot[i]   = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_hready", hready[0], 1);
    check("rst_hresp", hresp[0], 0);
    check("rst_hrdata", hrdata[0], 0);
    check("rst_sram_addr", sram_addr[0], 0);
    check("rst_ren_wen", {sram_ren[0], sram_wen[0]}, 0);
    check("rst_sram_wdata", sram_wdata[0], 0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Basic read, write, read-back
    issue(0, 0, 32'h10, 0, 0, 0);
    wait_idle(0);
    issue(0, 1, 32'h20, 32'hDEAD_BEEF, 0, 0);
    wait_idle(0);
    issue(0, 0, 32'h20, 0, 0, 0);
    wait_idle(0);

    // Misaligned read: two-cycle hresp, then clear
    issue(0, 0, 32'h22, 0, 0, 0);
    @(negedge clk);
    check("err_cycle_hresp", hresp[0], 1);
    check("err_cycle_hready", hready[0], 0);
    @(negedge clk);
    check("err_done_hresp", hresp[0], 1);
    @(negedge clk);
    check("err_after_hresp", hresp[0], 0);
    issue(0, 0, 32'h0004_0000, 0, 0, 0);
    wait_idle(0);
    issue(0, 1, 32'h0000_0021, 32'h1234_5678, 0, 0);
    wait_idle(0);

    // Back-to-back with hsel held: no idle gaps
    issue(0, 1, 32'h0, 32'h1111_2222, 1, 0);
    c0 = cyc;
    issue(0, 0, 32'h0, 0, 1, 0);
    issue(0, 1, 32'h4, 32'h3333_4444, 0, 0);
    wait_idle(0);
    check("b2b_total_cycles", 64'(cyc - c0), 64'd8);

    // Reset during RD_WAIT abandons the read
    issue(0, 0, 32'h10, 0, 0, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    r0 = ren_tot[0];
    @(negedge clk);
    check("midrst_hready", hready[0], 1);
    check("midrst_hrdata", hrdata[0], 0);
    repeat (4) @(negedge clk);
    check("midrst_late_hrdata", hrdata[0], 0);
    check("midrst_no_ren", 64'(ren_tot[0] - r0), 0);
    issue(0, 0, 32'h20, 0, 0, 0);
    wait_idle(0);

    // Latency sweep
    for (int i = 1; i < N; i++) begin
      issue(i, 1, 32'h40, 32'h5A5A_0000 + 32'(i), 0, 0);
      issue(i, 0, 32'h40, 0, 0, 0);
      issue(i, 0, 32'h10, 0, 0, 0);
      wait_idle(i);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) check($sformatf("u%0d_sb_drained", i), 64'(sb[i].size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
